imem_loader: RTL and testbench

//   Hardware counterpart to the simulation-time instruction load. Accepts a byte stream
//   (count, instruction words MSB-first, checksum) and writes it into Instruction_Memory.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_word_assembler.sv | 41 ++++
 rtl/imem_loader.sv | 144 ++++++++++++++
 tb/tb_imem_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings
// and the instruction word width.
package imem_loader_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CHK  = 3'd2,
        ST_FILL = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs four host bytes, MSB first, into one instruction word and flags the
// byte that completes it.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_en_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_ready_o
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (byte_en_i) begin
            shift_d = {shift_q[15:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // The completed word includes the byte being accepted this cycle, so the
    // parent can register it on the same edge.
    assign word_o       = {shift_q, byte_i};
    assign word_ready_o = byte_en_i && (cnt_q == 2'd3);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (count, words, checksum) into instruction memory,
// zero-fills the remainder and then releases the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              byte_ready_o,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_start_o,
    output logic              done_o,
    output logic              err_o
);

    // Word counts run 0..256, so nine bits cover every legal depth.
    localparam logic [8:0] DEPTH_C = 9'(DEPTH);

    state_e            state_q, state_d;
    logic [8:0]        n_q, n_d;
    logic [8:0]        widx_q, widx_d;
    logic [7:0]        sum_q, sum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;

    logic              accept;
    logic              asm_en;
    logic [WORD_W-1:0] asm_word;
    logic              asm_ready;

    assign byte_ready_o = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CHK);
    assign accept       = byte_valid_i && byte_ready_o;
    assign asm_en       = accept && (state_q == ST_DATA);

    word_assembler u_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .byte_en_i    (asm_en),
        .byte_i       (byte_i),
        .word_o       (asm_word),
        .word_ready_o (asm_ready)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        widx_d  = widx_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    n_d     = (byte_i == 8'd0) ? 9'd256 : {1'b0, byte_i};
                    sum_d   = byte_i;
                    widx_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    sum_d = sum_q + byte_i;
                    if (asm_ready) begin
                        // Words beyond the memory are checksummed but never written.
                        if (widx_q < DEPTH_C) begin
                            we_d   = 1'b1;
                            addr_d = ADDR_W'(widx_q);
                            data_d = asm_word;
                        end
                        widx_d = widx_q + 9'd1;
                        if (widx_q == n_q - 9'd1) begin
                            state_d = ST_CHK;
                        end
                    end
                end
            end
            ST_CHK: begin
                if (accept) begin
                    if (byte_i == sum_q) begin
                        state_d = (n_q >= DEPTH_C) ? ST_RUN : ST_FILL;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_FILL: begin
                // The RUN transition waits one cycle past the last write so
                // start trails the final strobe.
                if (widx_q < DEPTH_C) begin
                    we_d   = 1'b1;
                    addr_d = ADDR_W'(widx_q);
                    data_d = '0;
                    widx_d = widx_q + 9'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
            end
            ST_ERR: begin
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_HDR;
            n_q     <= '0;
            widx_q  <= '0;
            sum_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            widx_q  <= widx_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign imem_we_o   = we_q;
    assign imem_addr_o = addr_q;
    assign imem_data_o = data_q;
    assign cpu_start_o = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_RUN);
    assign err_o       = (state_q == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame vectors from a table, a write scoreboard, and
// hand-built sequences for mid-frame reset and input activity after the load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready_o;
    logic        imem_we_o;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_data_o;
    logic        cpu_start_o;
    logic        done_o;
    logic        err_o;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .byte_valid_i (byte_valid),
        .byte_i       (byte_in),
        .byte_ready_o (byte_ready_o),
        .imem_we_o    (imem_we_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_o  (imem_data_o),
        .cpu_start_o  (cpu_start_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int nwords;
        bit fixed;
        bit bad_chk;
        int max_gap;
        bit exp_start;
        bit exp_err;
        bit exp_ready;
    } vec_t;

    wr_t        exp_q[$];
    vec_t       vecs[6];
    logic [7:0] fixed_bytes[8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    int         compared   = 0;
    int         mismatched = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic checkb(input string name, input logic got, input logic exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic monitor_loop();
        wr_t e;
        forever begin
            @(negedge clk);
            if (imem_we_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write at %0t",
                             imem_addr_o, imem_data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(imem_addr_o), 32'(e.addr));
                    check("wr_data", imem_data_o, e.data);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkb({tag, "_ready"}, byte_ready_o, 1'b1);
        checkb({tag, "_we"}, imem_we_o, 1'b0);
        check({tag, "_addr"}, 32'(imem_addr_o), 32'h0);
        check({tag, "_data"}, imem_data_o, 32'h0);
        checkb({tag, "_start"}, cpu_start_o, 1'b0);
        checkb({tag, "_done"}, done_o, 1'b0);
        checkb({tag, "_err"}, err_o, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i      = 1'b1;
        byte_valid = 1'b0;
        exp_q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        gap = int'($urandom_range(max_gap, 0));
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        checkb("ready_before_byte", byte_ready_o, 1'b1);
        byte_valid = 1'b1;
        byte_in    = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    // Builds the frame, queues every expected write, then drives it byte by byte.
    task automatic run_vec(input int vi, input int nbytes_limit);
        vec_t       v;
        logic [7:0] frame[$];
        logic [7:0] sum;
        logic [7:0] b;
        logic [31:0] word;
        wr_t        w;
        bit         got;
        bit         prev_we;
        v = vecs[vi];
        do_reset();
        b = (v.nwords == 256) ? 8'h00 : 8'(v.nwords);
        frame.push_back(b);
        sum  = b;
        word = '0;
        for (int wi = 0; wi < v.nwords; wi++) begin
            for (int k = 0; k < 4; k++) begin
                b = v.fixed ? fixed_bytes[wi * 4 + k] : 8'($urandom_range(255, 0));
                frame.push_back(b);
                sum  = sum + b;
                word = {word[23:0], b};
            end
            w.addr = 8'(wi);
            w.data = word;
            if (nbytes_limit < 0 || (wi + 1) * 4 + 1 <= nbytes_limit) exp_q.push_back(w);
        end
        frame.push_back(v.bad_chk ? sum + 8'd1 : sum);
        if (nbytes_limit >= 0) begin
            for (int i = 0; i < nbytes_limit; i++) send_byte(frame[i], v.max_gap);
            return;
        end
        if (!v.bad_chk) begin
            for (int a = v.nwords; a < 256; a++) begin
                w.addr = 8'(a);
                w.data = 32'h0;
                exp_q.push_back(w);
            end
        end
        foreach (frame[i]) send_byte(frame[i], v.max_gap);

        got     = 1'b0;
        prev_we = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (cpu_start_o || err_o) begin
                got = 1'b1;
                break;
            end
            prev_we = imem_we_o;
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL vec%0d_timeout: got no start/err expected one within 600 cycles", vi);
        end
        if (v.nwords < 256 && !v.bad_chk) checkb("start_after_last_write", prev_we, 1'b1);
        checkb("we_at_end", imem_we_o, 1'b0);
        repeat (5) @(negedge clk);
        checkb("start", cpu_start_o, v.exp_start);
        checkb("done", done_o, v.exp_start);
        checkb("err", err_o, v.exp_err);
        checkb("ready", byte_ready_o, v.exp_ready);
        check("writes_outstanding", 32'(exp_q.size()), 32'd0);
        $display("vec %0d: nwords=%0d bad_chk=%0b gap<=%0d start=%0b err=%0b",
                 vi, v.nwords, v.bad_chk, v.max_gap, cpu_start_o, err_o);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected one before 2 ms");
        $fatal(1);
    end

    initial begin
        rst_i      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        vecs[0] = '{nwords: 2,   fixed: 1'b1, bad_chk: 1'b0, max_gap: 0, exp_start: 1'b1, exp_err: 1'b0, exp_ready: 1'b0};
        vecs[1] = '{nwords: 2,   fixed: 1'b1, bad_chk: 1'b1, max_gap: 0, exp_start: 1'b0, exp_err: 1'b1, exp_ready: 1'b0};
        vecs[2] = '{nwords: 2,   fixed: 1'b1, bad_chk: 1'b0, max_gap: 3, exp_start: 1'b1, exp_err: 1'b0, exp_ready: 1'b0};
        vecs[3] = '{nwords: 256, fixed: 1'b0, bad_chk: 1'b0, max_gap: 0, exp_start: 1'b1, exp_err: 1'b0, exp_ready: 1'b0};
        vecs[4] = '{nwords: 5,   fixed: 1'b0, bad_chk: 1'b0, max_gap: 2, exp_start: 1'b1, exp_err: 1'b0, exp_ready: 1'b0};
        vecs[5] = '{nwords: 1,   fixed: 1'b0, bad_chk: 1'b1, max_gap: 1, exp_start: 1'b0, exp_err: 1'b1, exp_ready: 1'b0};

        fork
            monitor_loop();
        join_none

        #1;
        check_reset_outputs("por");

        for (int i = 0; i < 6; i++) run_vec(i, -1);

        // Reset arriving mid-cycle while the first word's strobe is still high.
        run_vec(0, 5);
        @(negedge clk);
        checkb("pre_reset_we", imem_we_o, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        check("async_rst_pending", 32'(exp_q.size()), 32'd0);
        #1;
        rst_i = 1'b0;
        $display("reset mid-frame after 5 bytes");
        run_vec(0, -1);

        // Bytes offered after the load must be ignored.
        for (int c = 0; c < 20; c++) begin
            byte_valid = 1'b1;
            byte_in    = 8'($urandom_range(255, 0));
            @(negedge clk);
            checkb("run_start", cpu_start_o, 1'b1);
            checkb("run_done", done_o, 1'b1);
            checkb("run_err", err_o, 1'b0);
            checkb("run_ready", byte_ready_o, 1'b0);
            checkb("run_we", imem_we_o, 1'b0);
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        $display("run hold: 20 cycles of ignored bytes");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
